// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel gradient block.
package sobel_pkg;

  localparam logic [1:0] DIR_0   = 2'd0;
  localparam logic [1:0] DIR_45  = 2'd1;
  localparam logic [1:0] DIR_90  = 2'd2;
  localparam logic [1:0] DIR_135 = 2'd3;

  // Signed width that holds a full Sobel response without overflow.
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image row of pixel history: synchronous write, combinational read at the same address.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  localparam int AW   = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [IMG_W];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wdata;
  end

  // Read-before-write: the tap sees the previous row's pixel at this column.
  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel: raster pixels in, |Gx|+|Gy| and a quantised direction out
// for every interior pixel. Three enabled stages: window, gradients, magnitude/direction.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int MAG_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] out_mag,
  output logic [1:0]       out_dir,
  output logic             out_sof,
  output logic             out_eol
);

  localparam int GW     = grad_w(PIX_W);
  localparam int SW     = PIX_W + 4;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = 16;
  localparam int STAGES = 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  logic          en, acc;
  logic [RW-1:0] row, p_row;
  logic [CW-1:0] col, p_col;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign acc      = in_valid && en;

  // A start-of-frame pixel lands at (0,0) regardless of where the counters were.
  assign p_row = in_sof ? '0 : row;
  assign p_col = in_sof ? '0 : col;

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (acc) begin
      if (p_col == COL_LAST) begin
        col <= '0;
        row <= (p_row == '1) ? p_row : p_row + 1'b1;
      end else begin
        col <= p_col + 1'b1;
        row <= p_row;
      end
    end
  end

  // ---------------- line buffers ----------------
  logic [PIX_W-1:0] lb0_q, lb1_q;

  sobel_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb0 (
    .clk   (clk),
    .en    (acc),
    .addr  (p_col),
    .wdata (in_pix),
    .rdata (lb0_q)
  );

  sobel_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb1 (
    .clk   (clk),
    .en    (acc),
    .addr  (p_col),
    .wdata (lb0_q),
    .rdata (lb1_q)
  );

  // ---------------- S1: window ----------------
  logic [2:0][2:0][PIX_W-1:0] win;
  logic [STAGES:0]            vld_pipe, sof_pipe, eol_pipe;
  logic                       vld_new, sof_new, eol_new;

  assign vld_new = acc && (p_row >= RW'(2)) && (p_col >= CW'(2));
  assign sof_new = (p_row == RW'(2)) && (p_col == CW'(2));
  assign eol_new = (p_col == COL_LAST);

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb1_q;
      win[1][2] <= lb0_q;
      win[2][2] <= in_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
      eol_pipe <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], vld_new};
      sof_pipe <= {sof_pipe[STAGES-1:0], sof_new};
      eol_pipe <= {eol_pipe[STAGES-1:0], eol_new};
    end
  end

  // ---------------- S2: gradients ----------------
  logic signed [GW-1:0] px [3][3];
  logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;

  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        px[i][j] = $signed({{(GW-PIX_W){1'b0}}, win[i][j]});
    gx_c = (px[0][2] + (px[1][2] <<< 1) + px[2][2])
         - (px[0][0] + (px[1][0] <<< 1) + px[2][0]);
    gy_c = (px[2][0] + (px[2][1] <<< 1) + px[2][2])
         - (px[0][0] + (px[0][1] <<< 1) + px[0][2]);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      gx_q <= gx_c;
      gy_q <= gy_c;
    end
  end

  // ---------------- S3: magnitude and direction ----------------
  logic [GW-1:0]        ax, ay, fax;
  logic signed [GW-1:0] fx, fy;
  logic [SW-1:0]        mag_sum;
  logic [MAG_W-1:0]     mag_sat;
  logic [1:0]           dir_c;

  always_comb begin
    ax      = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    ay      = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    mag_sum = {1'b0, ax} + {1'b0, ay};
    // Fold into the upper half-plane so only 0..180 degrees need resolving.
    fx      = gy_q[GW-1] ? -gx_q : gx_q;
    fy      = gy_q[GW-1] ? -gy_q : gy_q;
    fax     = fx[GW-1] ? GW'(-fx) : GW'(fx);
    if (fx == '0 && fy == '0)          dir_c = DIR_0;
    else if ({fy, 1'b0} < {1'b0, fax}) dir_c = DIR_0;
    else if ({1'b0, fy} > {fax, 1'b0}) dir_c = DIR_90;
    else if (!fx[GW-1])                dir_c = DIR_45;
    else                               dir_c = DIR_135;
  end

  if (MAG_W >= SW) begin : g_mag_wide
    assign mag_sat = MAG_W'(mag_sum);
  end else begin : g_mag_clamp
    assign mag_sat = (|mag_sum[SW-1:MAG_W]) ? '1 : mag_sum[MAG_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_mag <= '0;
      out_dir <= DIR_0;
    end else if (en) begin
      out_mag <= mag_sat;
      out_dir <= dir_c;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_sof   = sof_pipe[STAGES];
  assign out_eol   = eol_pipe[STAGES];

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on a 4-pixel-wide image; a second instance with an
// 8-bit magnitude runs in lockstep to check saturation.
module tb_sobel_stream;

  localparam int PIX_W = 8;
  localparam int IMG_W = 4;
  localparam int MAG_W = 11;
  localparam int MAG_S = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_sof, out_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_ready, out_valid, out_sof, out_eol;
  logic [MAG_W-1:0] out_mag;
  logic [1:0]       out_dir;
  logic             s_in_ready, s_out_valid, s_out_sof, s_out_eol;
  logic [MAG_S-1:0] s_out_mag;
  logic [1:0]       s_out_dir;

  always #5 clk = ~clk;

  sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .MAG_W(MAG_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag),
    .out_dir(out_dir), .out_sof(out_sof), .out_eol(out_eol)
  );

  sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .MAG_W(MAG_S)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_pix(in_pix),
    .in_sof(in_sof), .out_valid(s_out_valid), .out_ready(out_ready), .out_mag(s_out_mag),
    .out_dir(s_out_dir), .out_sof(s_out_sof), .out_eol(s_out_eol)
  );

  typedef struct {
    int mag;
    int dir;
    bit sof;
    bit eol;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0;
  int   img [3][IMG_W];
  int   mrow = 0, mcol = 0;
  int   n_out = 0;
  int   sof_acc_cyc = -100, sof_out_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int r, input int c);
    exp_t e;
    int p [3][3];
    int gx, gy, x, y, ax;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[(r - 2 + i) % 3][c - 2 + j];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    e.mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (e.mag > 2047) e.mag = 2047;
    x  = (gy < 0) ? -gx : gx;
    y  = (gy < 0) ? -gy : gy;
    ax = (x < 0) ? -x : x;
    if (x == 0 && y == 0) e.dir = 0;
    else if (2*y < ax)    e.dir = 0;
    else if (y > 2*ax)    e.dir = 2;
    else if (x > 0)       e.dir = 1;
    else                  e.dir = 3;
    e.sof = (r == 2 && c == 2);
    e.eol = (c == IMG_W - 1);
    return e;
  endfunction

  function automatic int pix_at(input int pat, input int r, input int c);
    case (pat)
      0: return 50;
      1: return (c < 2) ? 0 : 100;
      2: return (r < 2) ? 0 : 100;
      3: return 20 * (r + c);
      4: return 20 * (r + 3 - c);
      5: return (r == 0 && c == 0) ? 0 : (r == 2 && c == 2) ? 100 : 50;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Output monitor: a transfer happens at the next posedge when valid && ready here.
  initial begin
    exp_t e;
    int   es;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got mag=%0d with empty scoreboard", out_mag);
        end else begin
          e  = q.pop_front();
          es = (e.mag > 255) ? 255 : e.mag;
          if (e.sof) sof_out_cyc = cyc;
          n_cmp++; if (int'(out_mag) !== e.mag) begin n_err++; $display("FAIL out_mag: got %0d expected %0d", out_mag, e.mag); end
          n_cmp++; if (int'(out_dir) !== e.dir) begin n_err++; $display("FAIL out_dir: got %0d expected %0d", out_dir, e.dir); end
          n_cmp++; if (out_sof !== e.sof) begin n_err++; $display("FAIL out_sof: got %0b expected %0b", out_sof, e.sof); end
          n_cmp++; if (out_eol !== e.eol) begin n_err++; $display("FAIL out_eol: got %0b expected %0b", out_eol, e.eol); end
          n_cmp++; if (s_out_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid: got %0b expected 1", s_out_valid); end
          n_cmp++; if (int'(s_out_mag) !== es) begin n_err++; $display("FAIL sat_mag: got %0d expected %0d", s_out_mag, es); end
        end
      end
    end
  end

  task automatic push_pix(input int pix, input bit sof);
    int w = 0;
    bit ok = 1'b0;
    exp_t e;
    in_valid = 1'b1;
    in_pix   = PIX_W'(pix);
    in_sof   = sof;
    forever begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      w++;
      if (w > 50) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", w);
        break;
      end
    end
    if (ok) begin
      if (sof) begin mrow = 0; mcol = 0; end
      img[mrow % 3][mcol] = pix;
      if (mrow >= 2 && mcol >= 2) begin
        e = model(mrow, mcol);
        q.push_back(e);
        if (e.sof) sof_acc_cyc = cyc;
      end
      if (mcol == IMG_W - 1) begin mcol = 0; mrow++; end
      else mcol++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int pat, input int rows, input bit with_sof);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < IMG_W; c++)
        push_pix(pix_at(pat, r, c), with_sof && r == 0 && c == 0);
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (q.size() != 0 && w < 40) begin @(negedge clk); w++; end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin n_err++; $display("FAIL %s_drain: got %0d pending expected 0", name, q.size()); end
  endtask

  task automatic check_count(input string name, input int exp_n);
    n_cmp++;
    if (n_out !== exp_n) begin n_err++; $display("FAIL %s_count: got %0d expected %0d", name, n_out, exp_n); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (out_mag !== '0) begin n_err++; $display("FAIL rst_mag: got %0d expected 0", out_mag); end
    n_cmp++; if (out_dir !== 2'd0) begin n_err++; $display("FAIL rst_dir: got %0d expected 0", out_dir); end
    n_cmp++; if (out_sof !== 1'b0 || out_eol !== 1'b0) begin n_err++; $display("FAIL rst_flags: got sof=%0b eol=%0b expected 0 0", out_sof, out_eol); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
    mrow = 0; mcol = 0;
  endtask

  task automatic test_flat();
    n_out = 0;
    send_frame(0, 4, 1'b1);
    drain("flat");
    check_count("flat", 4);
  endtask

  task automatic test_vert_edge();
    n_out = 0;
    send_frame(1, 4, 1'b1);
    drain("vert");
    check_count("vert", 4);
    n_cmp++;
    if (sof_out_cyc - sof_acc_cyc !== 3) begin
      n_err++; $display("FAIL latency: got %0d expected 3", sof_out_cyc - sof_acc_cyc);
    end
  endtask

  task automatic test_patterns();
    for (int p = 2; p <= 5; p++) begin
      n_out = 0;
      send_frame(p, 4, 1'b1);
      drain("pattern");
      check_count("pattern", 4);
    end
  endtask

  task automatic test_back_to_back();
    n_out = 0;
    for (int i = 0; i < 6; i++) push_pix(pix_at(6, 0, 0), i == 0);
    send_frame(1, 4, 1'b1);
    send_frame(6, 5, 1'b1);
    drain("b2b");
    check_count("b2b", 10);
  endtask

  task automatic test_backpressure();
    n_out = 0;
    fork
      send_frame(6, 4, 1'b1);
      begin
        int w = 0;
        logic [MAG_W-1:0] hm;
        logic [1:0]       hd;
        do begin @(posedge clk); #1; w++; end while (!out_valid && w < 60);
        out_ready = 1'b0;
        hm = out_mag; hd = out_dir;
        repeat (5) begin
          @(negedge clk);
          n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %0b expected 0", in_ready); end
          n_cmp++; if (out_valid !== 1'b1 || out_mag !== hm || out_dir !== hd) begin
            n_err++; $display("FAIL stall_hold: got v=%0b mag=%0d dir=%0d expected v=1 mag=%0d dir=%0d", out_valid, out_mag, out_dir, hm, hd);
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain("stall");
    check_count("stall", 4);
  endtask

  task automatic test_reset_mid();
    n_out = 0;
    for (int i = 0; i < 11; i++) push_pix(pix_at(6, 0, 0), i == 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    mrow = 0; mcol = 0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %0b expected 1", in_ready); end
    send_frame(1, 4, 1'b0);
    drain("midrst");
    check_count("midrst", 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_flat();
    test_vert_edge();
    test_patterns();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
